// File: rtl/t120_stream_pkg.sv
// Shared stream definitions for the framebuffer read/write width converters.
package t120_stream_pkg;

  localparam int PIXEL_WIDTH   = 16;
  localparam int DEFAULT_RATIO = 8;

  // Word-plus-flag entry at the default framebuffer word width.
  typedef struct packed {
    logic [PIXEL_WIDTH*DEFAULT_RATIO-1:0] data;
    logic                                 last;
  } word_entry_t;

  // Counter width for n states; never narrower than one bit.
  function automatic int clog2_min1(input int n);
    int w;
    w = 1;
    while ((1 << w) < n) w++;
    return w;
  endfunction

endpackage

// File: rtl/axi_unpack_if.sv
// Wide-word input stream and narrow-beat output stream of the unpacker.
interface axi_unpack_if import t120_stream_pkg::*; #(
  parameter int IN_WIDTH  = PIXEL_WIDTH*DEFAULT_RATIO,
  parameter int OUT_WIDTH = PIXEL_WIDTH
);
  logic [IN_WIDTH-1:0]  in_data;
  logic                 in_last;
  logic                 in_valid;
  logic                 in_ready;
  logic [OUT_WIDTH-1:0] out_data;
  logic                 out_last;
  logic                 out_valid;
  logic                 out_ready;

  modport slave (
    input  in_data, in_last, in_valid, out_ready,
    output in_ready, out_data, out_last, out_valid
  );

  modport master (
    output in_data, in_last, in_valid, out_ready,
    input  in_ready, out_data, out_last, out_valid
  );
endinterface

// File: rtl/axi_unpack.sv
// Stream width downsizer: wide words in, RATIO narrow beats out per word.
// All outputs (including in_ready) are flops; no input-to-output path.
// Optional build macro AXI_UNPACK_MSB_FIRST_EN: emit the most significant
// slice of each word first instead of the least significant.
//
// state   | meaning
// --------+-------------------------------------------------
// S_EMPTY | no word held, out_valid low
// S_CUR   | cur holds the word being emitted, stage empty
// S_BOTH  | cur emitting and stage holds the next word
module axi_unpack import t120_stream_pkg::*; #(
  parameter int IN_WIDTH  = PIXEL_WIDTH*DEFAULT_RATIO,
  parameter int OUT_WIDTH = PIXEL_WIDTH
) (
  input logic         clk,
  input logic         rstn,
  axi_unpack_if.slave bus
);

  localparam int RATIO = IN_WIDTH / OUT_WIDTH;
  localparam int CNT_W = clog2_min1(RATIO);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RATIO - 1);

  if (RATIO < 2 || IN_WIDTH != RATIO*OUT_WIDTH) begin : g_bad_cfg
    $error("axi_unpack: IN_WIDTH must equal RATIO*OUT_WIDTH with RATIO >= 2");
  end

  typedef enum logic [1:0] {S_EMPTY, S_CUR, S_BOTH} state_t;

  typedef struct packed {
    logic [IN_WIDTH-1:0] data;
    logic                last;
  } entry_t;

  state_t               state, state_nxt;
  entry_t               cur, cur_nxt, stage, stage_nxt, in_entry;
  logic [CNT_W-1:0]     cnt, cnt_nxt;
  logic                 in_fire, out_fire, vacate;
  logic [OUT_WIDTH-1:0] slice_nxt;

  assign in_entry = '{data: bus.in_data, last: bus.in_last};
  assign in_fire  = bus.in_valid & bus.in_ready;
  assign out_fire = bus.out_valid & bus.out_ready;
  assign vacate   = out_fire & (cnt == CNT_LAST);

  // Occupancy state register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= S_EMPTY;
    else       state <= state_nxt;
  end

  // Next occupancy, word routing (cur vs stage) and beat counter.
  always_comb begin
    state_nxt = state;
    cur_nxt   = cur;
    stage_nxt = stage;
    cnt_nxt   = cnt;
    if (vacate)        cnt_nxt = '0;
    else if (out_fire) cnt_nxt = cnt + CNT_W'(1);
    case (state)
      S_EMPTY: begin
        if (in_fire) begin
          cur_nxt   = in_entry;
          state_nxt = S_CUR;
        end
      end
      S_CUR: begin
        if (vacate) begin
          if (in_fire) cur_nxt   = in_entry;
          else         state_nxt = S_EMPTY;
        end else if (in_fire) begin
          stage_nxt = in_entry;
          state_nxt = S_BOTH;
        end
      end
      S_BOTH: begin
        // in_ready is low here, so only the stage-to-cur handoff can occur.
        if (vacate) begin
          cur_nxt   = stage;
          state_nxt = S_CUR;
        end
      end
      default: state_nxt = S_EMPTY;
    endcase
  end

  // Select the slice the next cycle presents; a mux avoids a variable shifter.
  always_comb begin
    slice_nxt = '0;
    for (int k = 0; k < RATIO; k++) begin
      if (cnt_nxt == CNT_W'(k)) begin
`ifdef AXI_UNPACK_MSB_FIRST_EN
        slice_nxt = cur_nxt.data[(RATIO-1-k)*OUT_WIDTH +: OUT_WIDTH];
`else
        slice_nxt = cur_nxt.data[k*OUT_WIDTH +: OUT_WIDTH];
`endif
      end
    end
  end

  // Datapath storage and registered outputs, all computed from next state.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cur           <= '0;
      stage         <= '0;
      cnt           <= '0;
      bus.in_ready  <= 1'b0;
      bus.out_valid <= 1'b0;
      bus.out_data  <= '0;
      bus.out_last  <= 1'b0;
    end else begin
      cur           <= cur_nxt;
      stage         <= stage_nxt;
      cnt           <= cnt_nxt;
      bus.in_ready  <= (state_nxt != S_BOTH);
      bus.out_valid <= (state_nxt != S_EMPTY);
      bus.out_data  <= (state_nxt == S_EMPTY) ? '0 : slice_nxt;
      bus.out_last  <= (state_nxt != S_EMPTY) & cur_nxt.last & (cnt_nxt == CNT_LAST);
    end
  end

endmodule

// File: tb/tb_axi_unpack.sv
// Self-checking bench for axi_unpack at IN=32, OUT=8 (four beats per word).
module tb_axi_unpack;

  localparam int IW = 32;
  localparam int OW = 8;
  localparam int R  = IW / OW;

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  axi_unpack_if #(.IN_WIDTH(IW), .OUT_WIDTH(OW)) bus ();

  axi_unpack #(.IN_WIDTH(IW), .OUT_WIDTH(OW)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  typedef struct packed {
    logic [OW-1:0] d;
    logic          l;
  } beat_t;

  typedef struct {
    logic [IW-1:0] w;
    logic          l;
    logic [OW-1:0] b [R];
  } vec_t;

  beat_t         q[$];
  int            total = 0;
  int            bad   = 0;
  bit            mon_en  = 0;
  bit            bp_done = 0;
  bit            hold_v  = 0;
  logic [OW-1:0] hold_d;
  logic          hold_l;
  int            occ;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [OW-1:0] slice(input logic [IW-1:0] w, input int k);
`ifdef AXI_UNPACK_MSB_FIRST_EN
    return w[(R-1-k)*OW +: OW];
`else
    return w[k*OW +: OW];
`endif
  endfunction

  // Scoreboard monitor: checks occupancy-derived flags, stall stability and beat data.
  always @(negedge clk) begin
    if (mon_en && rstn) begin
      occ = (q.size() + R - 1) / R;
      check("in_ready_vs_occ", 64'(bus.in_ready), 64'(occ < 2));
      check("out_valid_vs_occ", 64'(bus.out_valid), 64'(occ > 0));
      if (hold_v) begin
        check("stall_data", 64'(bus.out_data), 64'(hold_d));
        check("stall_last", 64'(bus.out_last), 64'(hold_l));
      end
      if (bus.out_valid) begin
        check("sb_has_entry", 64'(q.size() > 0), 64'(1));
        if (q.size() > 0) begin
          check("sb_data", 64'(bus.out_data), 64'(q[0].d));
          check("sb_last", 64'(bus.out_last), 64'(q[0].l));
        end
      end
      hold_v = bus.out_valid & ~bus.out_ready;
      hold_d = bus.out_data;
      hold_l = bus.out_last;
      if (bus.in_valid && bus.in_ready)
        for (int k = 0; k < R; k++) q.push_back('{d: slice(bus.in_data, k), l: bus.in_last && (k == R-1)});
      if (bus.out_valid && bus.out_ready && q.size() > 0) void'(q.pop_front());
    end else begin
      hold_v = 0;
    end
  end

  task automatic send(input logic [IW-1:0] d, input logic l);
    int n = 0;
    @(posedge clk); #1;
    bus.in_data  = d;
    bus.in_last  = l;
    bus.in_valid = 1'b1;
    @(negedge clk);
    while (!bus.in_ready && n < 500) begin @(negedge clk); n++; end
    if (n >= 500) check("send_timeout", 64'(bus.in_ready), 64'(1));
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic send_stream(input int nw, input int vpct);
    @(posedge clk); #1;
    for (int i = 0; i < nw; i++) begin
      int n = 0;
      while ($urandom_range(99) >= vpct) begin
        bus.in_valid = 1'b0;
        @(posedge clk); #1;
      end
      bus.in_data  = IW'($urandom);
      bus.in_last  = 1'($urandom_range(1));
      bus.in_valid = 1'b1;
      @(negedge clk);
      while (!bus.in_ready && n < 1000) begin @(negedge clk); n++; end
      if (n >= 1000) check("stream_timeout", 64'(bus.in_ready), 64'(1));
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic drain(input string nm);
    int n = 0;
    while (q.size() != 0 && n < 200) begin @(negedge clk); n++; end
    check(nm, 64'(q.size()), 64'(0));
  endtask

  vec_t vecs [5];

  initial begin
    bus.in_data   = '0;
    bus.in_last   = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;

    vecs[0] = '{w: 32'h44332211, l: 1'b1, b: '{8'h11, 8'h22, 8'h33, 8'h44}};
    vecs[1] = '{w: 32'hDEADBEEF, l: 1'b0, b: '{8'hEF, 8'hBE, 8'hAD, 8'hDE}};
    vecs[2] = '{w: 32'h00000000, l: 1'b1, b: '{8'h00, 8'h00, 8'h00, 8'h00}};
    vecs[3] = '{w: 32'hFFFFFFFF, l: 1'b0, b: '{8'hFF, 8'hFF, 8'hFF, 8'hFF}};
    vecs[4] = '{w: 32'h80A5C301, l: 1'b1, b: '{8'h01, 8'hC3, 8'hA5, 8'h80}};

    // Reset held five cycles, then in_ready rises only on the first edge.
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("rst_in_ready", 64'(bus.in_ready), 64'(0));
      check("rst_out_valid", 64'(bus.out_valid), 64'(0));
      check("rst_out_data", 64'(bus.out_data), 64'(0));
      check("rst_out_last", 64'(bus.out_last), 64'(0));
    end
    rstn = 1'b1;
    #1;
    check("rel_in_ready_before_edge", 64'(bus.in_ready), 64'(0));
    @(posedge clk); #1;
    check("rel_in_ready_after_edge", 64'(bus.in_ready), 64'(1));
    check("rel_out_valid", 64'(bus.out_valid), 64'(0));
    mon_en = 1;

    // Table: one word at a time, beats on consecutive cycles right after accept.
    bus.out_ready = 1'b1;
    for (int v = 0; v < 5; v++) begin
      send(vecs[v].w, vecs[v].l);
      for (int k = 0; k < R; k++) begin
        @(negedge clk);
        check("tbl_valid", 64'(bus.out_valid), 64'(1));
`ifdef AXI_UNPACK_MSB_FIRST_EN
        check("tbl_data", 64'(bus.out_data), 64'(vecs[v].b[R-1-k]));
`else
        check("tbl_data", 64'(bus.out_data), 64'(vecs[v].b[k]));
`endif
        check("tbl_last", 64'(bus.out_last), 64'(vecs[v].l && (k == R-1)));
      end
    end

    // Full throughput: continuous valid/ready keeps out_valid high for 400 beats.
    fork
      send_stream(100, 100);
      begin
        int n = 0;
        @(negedge clk);
        while (!bus.out_valid && n < 50) begin @(negedge clk); n++; end
        for (int b = 0; b < 100*R; b++) begin
          check("tp_no_bubble", 64'(bus.out_valid), 64'(1));
          @(negedge clk);
        end
      end
    join
    drain("tp_drain");

    // Random backpressure and bursty input.
    bp_done = 0;
    fork
      begin
        send_stream(1000, 70);
        bp_done = 1;
      end
      begin
        while (!bp_done) begin
          @(posedge clk); #1;
          bus.out_ready = 1'($urandom_range(1));
        end
      end
    join
    bus.out_ready = 1'b1;
    drain("bp_drain");

    // Reset during beat 2 of a word with the stage full.
    bus.out_ready = 1'b0;
    send(32'hA1A2A3A4, 1'b1);
    send(32'hB1B2B3B4, 1'b0);
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    @(negedge clk);
    check("both_full_in_ready", 64'(bus.in_ready), 64'(0));
    check("both_full_out_valid", 64'(bus.out_valid), 64'(1));
    mon_en = 0;
    #2;
    rstn = 1'b0;
    #1;
    check("midrst_out_valid", 64'(bus.out_valid), 64'(0));
    check("midrst_in_ready", 64'(bus.in_ready), 64'(0));
    check("midrst_out_last", 64'(bus.out_last), 64'(0));
    q.delete();
    repeat (3) @(negedge clk);
    rstn = 1'b1;
    @(posedge clk); #1;
    mon_en = 1;
    bus.out_ready = 1'b1;
    send(32'hC4C3C2C1, 1'b1);
    drain("post_rst_drain");
    repeat (6) @(negedge clk);
    check("post_rst_idle", 64'(bus.out_valid), 64'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/axi_unpack.md
Name: axi_unpack

Overview:
- Stream width downsizer. Accepts wide valid/ready words from the framebuffer memory read path and emits them as a sequence of narrow beats toward the pixel pipeline.
- Receive-side counterpart of the write-path packing. Fully registered outputs, so it can sit between timing-critical regions like the existing register slices.
- Sustains one output beat per clock with no bubbles across word boundaries.

Parameters:
- IN_WIDTH, 128, width of input word; must equal RATIO*OUT_WIDTH.
- OUT_WIDTH, 16, width of output beat.
- RATIO (localparam), IN_WIDTH/OUT_WIDTH, beats per word; must be ≥2 (elaboration-time assertion).

Ports:
- clk  in  1  clock
- rstn  in  1  reset, asynchronous, active-low
- in_data  in  IN_WIDTH  input word
- in_last  in  1  input word is last of packet/line
- in_valid  in  1  input word valid
- in_ready  out  1  block can accept a word (registered)
- out_data  out  OUT_WIDTH  output beat (registered)
- out_last  out  1  final beat of a word whose in_last was set (registered)
- out_valid  out  1  output beat valid (registered)
- out_ready  in  1  downstream accepts beat

Behaviour:
- Reset (rstn low, async): out_valid=0, out_data=0, out_last=0, in_ready=0, beat counter=0, stage empty. in_ready rises on the first clk edge after rstn deasserts.
- Storage:
  - cur register: word being emitted, plus its last flag.
  - beat counter: 0..RATIO-1.
  - stage register: next word, plus its last flag.
  - in_ready is a flop equal to ~stage_full (next-state), never combinational from out_ready.
- Input transfer: in_valid & in_ready at edge t.
  - Word goes to cur if cur is empty, or cur is vacating at t and stage is empty.
  - Otherwise the word goes to stage.
- Output transfer: out_valid & out_ready.
  - Counter increments and out_data presents the next slice.
  - Slice k = cur[k*OUT_WIDTH +: OUT_WIDTH]; LSB-first by default.
  - out_data/out_valid/out_last hold stable while out_valid & ~out_ready.
- Vacate: output transfer with counter==RATIO-1.
  - Counter returns to 0.
  - If stage full: stage moves to cur, stage becomes empty, out_valid stays 1.
  - Else if input transfer at same edge: the new word loads cur directly.
  - Else out_valid falls to 0.
- out_last = cur.last & (counter==RATIO-1); 0 on all other beats.
- Latency: word accepted at edge t → beat 0 valid after edge t (cycle t+1).
- Throughput: with continuous in_valid and out_ready, out_valid stays 1 every cycle.
- Boundaries:
  - Both cur and stage full: in_ready=0.
  - Input while stage full: impossible, since in_ready=0.
  - Simultaneous vacate + input with stage full: the handoff happens; the input is not accepted because in_ready was 0.
  - out_ready low indefinitely: state frozen, no data lost.
  - Reset mid-word: all partial data discarded, no beat emitted after reset.
- No combinational path from any input to any output.

Optional Feature:
- AXI_UNPACK_MSB_FIRST_EN defined: slice k = cur[(RATIO-1-k)*OUT_WIDTH +: OUT_WIDTH], so the most significant beat is emitted first.
- Not defined: LSB-first as above.
- All other timing is identical.

Decomposition:
- Shared package t120_stream_pkg holds:
  - function clog2_min1(n), for counter width (min 1 bit).
  - typedef for the cur/stage entry struct {data, last}, parameterized via width constants.
  - Default pixel width constant PIXEL_WIDTH=16.
- No sub-module. Datapath and control stay in one module; the counter is inline.

Test Plan:
- Reset/ready: hold rstn low 5 cycles, release → in_ready=0 until first edge, then 1; out_valid=0 throughout.
- Basic order: IN=32, OUT=8, send 0x44332211 with last=1, out_ready=1 → beats 0x11,0x22,0x33,0x44 on consecutive cycles; out_last only on 0x44. With AXI_UNPACK_MSB_FIRST_EN: 0x44,0x33,0x22,0x11.
- Full throughput: 100 random words back-to-back, out_ready=1 → 400 beats, out_valid=1 continuously after first beat, in_ready never blocks more than the handoff pattern allows, data matches scoreboard.
- Backpressure: random out_ready (50%) and in_valid (70%), 1000 words → no loss/duplication; out_data/out_last stable while stalled; in_ready=0 whenever cur and stage are both full.
- Reset mid-operation: assert rstn during beat 2 of a word with stage full → out_valid=0 immediately (async); after release, the next word sent emits only its own beats.
